pkt_inject_queue: RTL and testbench
===================================

Name: pkt_inject_queue

Overview:
- Local injection stage directly upstream of the node A interface (pkt_in); its output port drives the node's pkt_in_* signals.
- Accepts packets from the local IP and buffers them in two QoS-class FIFOs (high/low).
- Stamps the source coordinate and arbitrates high-over-low, with an anti-starvation limit.
- Discards packets whose target is the configured faulty node.

Parameters:
HP, 3, horizontal coordinate of the owning node (0-7)
VP, 3, vertical coordinate of the owning node (0-7)
DEPTH, 4, entries per class FIFO; power of two, >=2
STARVE_MAX, 8, consecutive high grants allowed while low is waiting (1-255)

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
pg_en  in  1  fault-drop enable
pg_node  in  6  faulty node coordinate {h[2:0],v[2:0]}
up_vld  in  1  IP packet valid
up_type  in  2  packet type
up_qos  in  1  1 = high class
up_tgt  in  6  target coordinate
up_data  in  8  payload
up_rdy  out  1  IP packet accepted when up_vld&up_rdy
pkt_in_vld  out  1  to node A interface
pkt_in_type  out  2
pkt_in_qos  out  1
pkt_in_src  out  6  always {HP[2:0],VP[2:0]}
pkt_in_tgt  out  6
pkt_in_data  out  8
pkt_in_rdy  in  1  node A-interface ready
drop_cnt  out  8  saturating count of fault-dropped packets
hi_occ  out  $clog2(DEPTH)+1  high FIFO occupancy
lo_occ  out  $clog2(DEPTH)+1  low FIFO occupancy

Behaviour:
- Reset is asynchronous and active-low. On reset: both FIFOs empty, pointers 0, drop_cnt=0, starve_cnt=0, grant lock cleared. Outputs: pkt_in_vld=0, up_rdy reflects empty FIFOs, occupancies 0. Reset mid-operation flushes all queued packets with no output glitch beyond vld dropping to 0.
- Drop rule: when pg_en=1 and up_tgt==pg_node:
  - up_rdy=1 regardless of FIFO state.
  - The packet is discarded on handshake.
  - drop_cnt increments and saturates at 255.
- Accept rule otherwise: up_rdy = !full of the FIFO selected by up_qos (combinational on up_qos; no dependence on pkt_in_rdy). A write to a full FIFO never occurs. A simultaneous read of the same FIFO does not make a full FIFO writable that cycle.
- Latency: a packet written at edge N into an empty queue appears on pkt_in_* after edge N (pkt_in_vld=1 in cycle N+1). There is no combinational up->out path.
- FIFOs: show-ahead. Pointers are $clog2(DEPTH)+1 bits and wrap modulo 2*DEPTH. full/empty are derived from MSB compare. Simultaneous read and write on a non-full, non-empty FIFO keeps occupancy constant.
- Arbitration states:
  - IDLE (no lock): when either FIFO is non-empty, select high if hi non-empty and (lo empty or starve_cnt<STARVE_MAX), else low. Set lock=1 with sel recorded.
  - LOCKED: pkt_in_* present the head of the sel FIFO. They stay stable until pkt_in_vld&pkt_in_rdy. On that handshake: pop, clear lock, update starve_cnt.
  - Selection is combinational in IDLE so vld is asserted in the same cycle a FIFO becomes non-empty. The lock register holds sel from the first valid cycle onward; a later arrival in the other class never changes a pending offer.
- starve_cnt:
  - +1 on a high grant while lo non-empty (saturates at STARVE_MAX).
  - Cleared on a low grant or whenever lo is empty.
- pkt_in_qos equals the class the packet was queued in.
- pkt_in_src ignores any IP-provided value; it is always the node's own coordinate.
- Back-to-back: with pkt_in_rdy held 1 and a FIFO non-empty, one packet per cycle.

Decomposition:
- Shared package maze_pkt_pkg:
  - Field widths: TYPE_W=2, COORD_W=6, DATA_W=8.
  - pkt_t struct {type,qos,src,tgt,data}.
  - Function coord(h,v) returning {h[2:0],v[2:0]}.
- Sub-module pkt_sync_fifo (parameter DEPTH, payload pkt_t, show-ahead, occupancy output), instantiated twice (hi/lo).
- Arbiter and drop logic stay in pkt_inject_queue.

Test Plan:
- Reset then single low packet tgt=6'o12 data=8'hA5 with pkt_in_rdy=1 -> pkt_in_vld high exactly one cycle after accept; src=6'o33, qos=0, data=A5.
- Fill high FIFO with 4 packets with pkt_in_rdy=0 -> up_rdy=0 for a 5th high packet, up_rdy=1 for a low packet. hi_occ=4, fields unchanged while stalled.
- Fault drop: pg_en=1, pg_node=6'o21; send 3 packets tgt=6'o21 -> all accepted, none output, drop_cnt=3. Then pg_en=0 with same tgt -> forwarded.
- Starvation: keep hi non-empty, 1 low packet queued, pkt_in_rdy=1 -> 8 high grants then the low packet, starve_cnt returns to 0.
- Stability: low offered with pkt_in_rdy=0, high arrives next cycle -> low stays on the port until handshake, then high.
- Assert rst_n low with 3 packets queued and vld=1 -> pkt_in_vld=0 immediately, occupancies 0, drop_cnt=0 after release.

Source files
------------

// File: rtl/maze_pkt_pkg.sv
// Shared packet definitions for the local injection path: field widths,
// the packet record and the node-coordinate helper.
package maze_pkt_pkg;

  localparam int TYPE_W  = 2;
  localparam int COORD_W = 6;
  localparam int DATA_W  = 8;

  typedef struct packed {
    logic [TYPE_W-1:0]  ptype;
    logic               qos;
    logic [COORD_W-1:0] src;
    logic [COORD_W-1:0] tgt;
    logic [DATA_W-1:0]  data;
  } pkt_t;

  typedef enum logic {
    ARB_IDLE   = 1'b0,
    ARB_LOCKED = 1'b1
  } arb_state_t;

  function automatic logic [COORD_W-1:0] coord(input logic [2:0] h, input logic [2:0] v);
    return {h, v};
  endfunction

endpackage

// File: rtl/pkt_sync_fifo.sv
// Show-ahead packet FIFO with wrap-bit pointers; head is valid whenever
// empty is low.
module pkt_sync_fifo
  import maze_pkt_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     wr_en,
  input  pkt_t                     wr_pkt,
  input  logic                     rd_en,
  output pkt_t                     head,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   occ
);

  localparam int AW = $clog2(DEPTH);

  pkt_t          mem [DEPTH];
  logic [AW:0]   wp;
  logic [AW:0]   rp;
  logic          do_wr;
  logic          do_rd;

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  assign full  = (wp[AW] != rp[AW]) && (wp[AW-1:0] == rp[AW-1:0]);
  assign empty = (wp == rp);
  assign occ   = wp - rp;
  assign head  = mem[rp[AW-1:0]];

  assign do_wr = wr_en && !full;
  assign do_rd = rd_en && !empty;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wp <= '0;
      rp <= '0;
    end else begin
      if (do_wr) wp <= wp + (AW+1)'(1);
      if (do_rd) rp <= rp + (AW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (do_wr) mem[wp[AW-1:0]] <= wr_pkt;
  end

endmodule

// File: rtl/pkt_inject_queue.sv
// Local injection stage: two QoS-class queues, fault-target discard and a
// high-over-low arbiter with a starvation limit feeding the node pkt_in port.
module pkt_inject_queue
  import maze_pkt_pkg::*;
#(
  parameter int HP         = 3,
  parameter int VP         = 3,
  parameter int DEPTH      = 4,
  parameter int STARVE_MAX = 8
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      pg_en,
  input  logic [COORD_W-1:0]        pg_node,
  input  logic                      up_vld,
  input  logic [TYPE_W-1:0]         up_type,
  input  logic                      up_qos,
  input  logic [COORD_W-1:0]        up_tgt,
  input  logic [DATA_W-1:0]         up_data,
  output logic                      up_rdy,
  output logic                      pkt_in_vld,
  output logic [TYPE_W-1:0]         pkt_in_type,
  output logic                      pkt_in_qos,
  output logic [COORD_W-1:0]        pkt_in_src,
  output logic [COORD_W-1:0]        pkt_in_tgt,
  output logic [DATA_W-1:0]         pkt_in_data,
  input  logic                      pkt_in_rdy,
  output logic [7:0]                drop_cnt,
  output logic [$clog2(DEPTH):0]    hi_occ,
  output logic [$clog2(DEPTH):0]    lo_occ
);

  localparam logic [7:0] STARVE_LIM = 8'(STARVE_MAX);

  pkt_t       up_pkt;
  pkt_t       hi_head;
  pkt_t       lo_head;
  pkt_t       out_pkt;
  logic       hi_full, hi_empty, lo_full, lo_empty;
  logic       drop_hit;
  logic       wr_hi, wr_lo;
  logic       rd_hi, rd_lo;
  logic       sel_idle, cur_sel, sel_q;
  logic       hs;
  logic [7:0] starve_cnt;
  arb_state_t state;

  // The source coordinate is stamped here; any IP-side notion of it is ignored.
  assign up_pkt = '{ptype: up_type, qos: up_qos, src: coord(3'(HP), 3'(VP)),
                    tgt: up_tgt, data: up_data};

  assign drop_hit = pg_en && (up_tgt == pg_node);
  assign up_rdy   = drop_hit || (up_qos ? !hi_full : !lo_full);
  assign wr_hi    = up_vld && !drop_hit &&  up_qos && !hi_full;
  assign wr_lo    = up_vld && !drop_hit && !up_qos && !lo_full;

  pkt_sync_fifo #(.DEPTH(DEPTH)) u_hi_fifo (
    .clk    (clk),
    .rst_n  (rst_n),
    .wr_en  (wr_hi),
    .wr_pkt (up_pkt),
    .rd_en  (rd_hi),
    .head   (hi_head),
    .full   (hi_full),
    .empty  (hi_empty),
    .occ    (hi_occ)
  );

  pkt_sync_fifo #(.DEPTH(DEPTH)) u_lo_fifo (
    .clk    (clk),
    .rst_n  (rst_n),
    .wr_en  (wr_lo),
    .wr_pkt (up_pkt),
    .rd_en  (rd_lo),
    .head   (lo_head),
    .full   (lo_full),
    .empty  (lo_empty),
    .occ    (lo_occ)
  );

  // Once an offer is on the port the recorded class wins over fresh priority.
  assign sel_idle   = !hi_empty && (lo_empty || (starve_cnt < STARVE_LIM));
  assign cur_sel    = (state == ARB_LOCKED) ? sel_q : sel_idle;
  assign pkt_in_vld = (state == ARB_LOCKED) || !hi_empty || !lo_empty;
  assign hs         = pkt_in_vld && pkt_in_rdy;
  assign rd_hi      = hs &&  cur_sel;
  assign rd_lo      = hs && !cur_sel;

  assign out_pkt     = cur_sel ? hi_head : lo_head;
  assign pkt_in_type = out_pkt.ptype;
  assign pkt_in_qos  = cur_sel;
  assign pkt_in_src  = out_pkt.src;
  assign pkt_in_tgt  = out_pkt.tgt;
  assign pkt_in_data = out_pkt.data;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ARB_IDLE;
      sel_q      <= 1'b0;
      starve_cnt <= '0;
      drop_cnt   <= '0;
    end else begin
      case (state)
        ARB_IDLE: begin
          if (pkt_in_vld && !hs) begin
            state <= ARB_LOCKED;
            sel_q <= cur_sel;
          end
        end
        ARB_LOCKED: begin
          if (hs) state <= ARB_IDLE;
        end
        default: state <= ARB_IDLE;
      endcase

      if (lo_empty)
        starve_cnt <= '0;
      else if (rd_lo)
        starve_cnt <= '0;
      else if (rd_hi && (starve_cnt < STARVE_LIM))
        starve_cnt <= starve_cnt + 8'd1;

      if (up_vld && drop_hit && (drop_cnt != 8'hFF))
        drop_cnt <= drop_cnt + 8'd1;
    end
  end

endmodule

// File: tb/tb_pkt_inject_queue.sv
// Bench for pkt_inject_queue: directed vector table, corner sequences and a
// randomized run scored against a queue-based reference model.
module tb_pkt_inject_queue;
  import maze_pkt_pkg::*;

  localparam int DEPTH      = 4;
  localparam int STARVE_MAX = 8;
  localparam int OW         = $clog2(DEPTH) + 1;
  localparam logic [5:0] SRC = 6'o33;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          pg_en = 1'b0;
  logic [5:0]    pg_node = '0;
  logic          up_vld = 1'b0;
  logic [1:0]    up_type = '0;
  logic          up_qos = 1'b0;
  logic [5:0]    up_tgt = '0;
  logic [7:0]    up_data = '0;
  logic          up_rdy;
  logic          pkt_in_vld;
  logic [1:0]    pkt_in_type;
  logic          pkt_in_qos;
  logic [5:0]    pkt_in_src;
  logic [5:0]    pkt_in_tgt;
  logic [7:0]    pkt_in_data;
  logic          pkt_in_rdy = 1'b0;
  logic [7:0]    drop_cnt;
  logic [OW-1:0] hi_occ;
  logic [OW-1:0] lo_occ;

  always #5 clk = ~clk;

  pkt_inject_queue #(.HP(3), .VP(3), .DEPTH(DEPTH), .STARVE_MAX(STARVE_MAX)) dut (
    .clk(clk), .rst_n(rst_n), .pg_en(pg_en), .pg_node(pg_node),
    .up_vld(up_vld), .up_type(up_type), .up_qos(up_qos), .up_tgt(up_tgt),
    .up_data(up_data), .up_rdy(up_rdy),
    .pkt_in_vld(pkt_in_vld), .pkt_in_type(pkt_in_type), .pkt_in_qos(pkt_in_qos),
    .pkt_in_src(pkt_in_src), .pkt_in_tgt(pkt_in_tgt), .pkt_in_data(pkt_in_data),
    .pkt_in_rdy(pkt_in_rdy), .drop_cnt(drop_cnt), .hi_occ(hi_occ), .lo_occ(lo_occ)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: per-class packet queues, the class of a pending offer
  // (-1 when none), the starvation count and the drop count.
  pkt_t hi_q[$];
  pkt_t lo_q[$];
  int   pend = -1;
  int   starve = 0;
  int   drops = 0;

  // Outputs sampled by the last step, for the table and the corner sequences.
  logic       s_rdy, s_vld, s_qos, s_hs;
  logic [7:0] s_data;
  int         s_ho, s_lo, s_drop;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    hi_q.delete();
    lo_q.delete();
    pend   = -1;
    starve = 0;
    drops  = 0;
  endtask

  // One clock: predict, compare at negedge, advance the model at posedge.
  task automatic step();
    logic drop, e_rdy, lo_was_empty;
    int   e_off;
    pkt_t exp_pkt, act_pkt;
    drop  = pg_en && (up_tgt == pg_node);
    e_rdy = drop || (up_qos ? (hi_q.size() < DEPTH) : (lo_q.size() < DEPTH));
    if (pend >= 0) e_off = pend;
    else if (hi_q.size() > 0 && (lo_q.size() == 0 || starve < STARVE_MAX)) e_off = 1;
    else if (lo_q.size() > 0) e_off = 0;
    else e_off = -1;

    @(negedge clk);
    chk("up_rdy", up_rdy, e_rdy);
    chk("pkt_in_vld", pkt_in_vld, e_off >= 0);
    if (e_off >= 0) begin
      exp_pkt = (e_off == 1) ? hi_q[0] : lo_q[0];
      act_pkt = '{ptype: pkt_in_type, qos: pkt_in_qos, src: pkt_in_src,
                  tgt: pkt_in_tgt, data: pkt_in_data};
      chk("pkt_fields", act_pkt, exp_pkt);
    end
    chk("hi_occ", hi_occ, hi_q.size());
    chk("lo_occ", lo_occ, lo_q.size());
    chk("drop_cnt", drop_cnt, drops);
    s_rdy = up_rdy; s_vld = pkt_in_vld; s_qos = pkt_in_qos; s_data = pkt_in_data;
    s_ho = int'(hi_occ); s_lo = int'(lo_occ); s_drop = int'(drop_cnt);
    s_hs = pkt_in_vld && pkt_in_rdy;

    @(posedge clk);
    lo_was_empty = (lo_q.size() == 0);
    if (e_off >= 0 && pkt_in_rdy) begin
      if (e_off == 1) begin
        void'(hi_q.pop_front());
        if (!lo_was_empty && starve < STARVE_MAX) starve++;
      end else begin
        void'(lo_q.pop_front());
        starve = 0;
      end
      pend = -1;
    end else if (e_off >= 0) begin
      pend = e_off;
    end
    if (lo_was_empty) starve = 0;
    if (up_vld && e_rdy) begin
      if (drop) begin
        if (drops < 255) drops++;
      end else if (up_qos) begin
        hi_q.push_back('{ptype: up_type, qos: 1'b1, src: SRC, tgt: up_tgt, data: up_data});
      end else begin
        lo_q.push_back('{ptype: up_type, qos: 1'b0, src: SRC, tgt: up_tgt, data: up_data});
      end
    end
    #1;
  endtask

  task automatic drive(input logic v, input logic q, input logic [5:0] t,
                       input logic [7:0] d, input logic r);
    up_vld = v; up_qos = q; up_tgt = t; up_data = d; pkt_in_rdy = r;
  endtask

  task automatic drain();
    drive(1'b0, 1'b0, 6'o00, 8'h00, 1'b1);
    for (int i = 0; i < 20 && (hi_q.size() > 0 || lo_q.size() > 0 || pend >= 0); i++) step();
    step();
    chk("drain_empty", {hi_occ, lo_occ}, '0);
  endtask

  typedef struct {
    logic uv, uq; logic [5:0] ut; logic [7:0] ud; logic pe; logic [5:0] pn; logic pr;
    logic er, ev, eq; logic [7:0] ed; int eho, elo, edr;
  } vec_t;
  vec_t tbl[$];

  task automatic add(input logic uv, input logic uq, input logic [5:0] ut, input logic [7:0] ud,
                     input logic pe, input logic [5:0] pn, input logic pr,
                     input logic er, input logic ev, input logic eq, input logic [7:0] ed,
                     input int eho, input int elo, input int edr);
    tbl.push_back('{uv, uq, ut, ud, pe, pn, pr, er, ev, eq, ed, eho, elo, edr});
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  initial begin
    int hi_grants, lo_seen;
    logic [5:0] tg [4];
    tg[0] = 6'o21; tg[1] = 6'o12; tg[2] = 6'o33; tg[3] = 6'o07;

    //              uv uq tgt    data  pe pn     pr  er ev eq data  ho lo drop
    add(0, 0, 6'o12, 8'h00, 0, 6'o00, 1,  1, 0, 0, 8'h00, 0, 0, 0);
    add(1, 0, 6'o12, 8'hA5, 0, 6'o00, 1,  1, 0, 0, 8'h00, 0, 0, 0);
    add(0, 0, 6'o12, 8'h00, 0, 6'o00, 1,  1, 1, 0, 8'hA5, 0, 1, 0);
    add(0, 0, 6'o12, 8'h00, 0, 6'o00, 1,  1, 0, 0, 8'h00, 0, 0, 0);
    add(1, 1, 6'o05, 8'h10, 0, 6'o00, 0,  1, 0, 0, 8'h00, 0, 0, 0);
    add(1, 1, 6'o05, 8'h11, 0, 6'o00, 0,  1, 1, 1, 8'h10, 1, 0, 0);
    add(1, 1, 6'o05, 8'h12, 0, 6'o00, 0,  1, 1, 1, 8'h10, 2, 0, 0);
    add(1, 1, 6'o05, 8'h13, 0, 6'o00, 0,  1, 1, 1, 8'h10, 3, 0, 0);
    add(1, 1, 6'o05, 8'h14, 0, 6'o00, 0,  0, 1, 1, 8'h10, 4, 0, 0);
    add(1, 0, 6'o05, 8'h20, 0, 6'o00, 0,  1, 1, 1, 8'h10, 4, 0, 0);
    add(0, 0, 6'o05, 8'h00, 0, 6'o00, 0,  1, 1, 1, 8'h10, 4, 1, 0);
    add(1, 1, 6'o21, 8'h30, 1, 6'o21, 0,  1, 1, 1, 8'h10, 4, 1, 0);
    add(1, 1, 6'o21, 8'h31, 1, 6'o21, 0,  1, 1, 1, 8'h10, 4, 1, 1);
    add(1, 1, 6'o21, 8'h32, 1, 6'o21, 0,  1, 1, 1, 8'h10, 4, 1, 2);
    add(0, 1, 6'o21, 8'h00, 1, 6'o21, 0,  1, 1, 1, 8'h10, 4, 1, 3);
    add(0, 0, 6'o21, 8'h00, 0, 6'o21, 1,  1, 1, 1, 8'h10, 4, 1, 3);
    add(0, 0, 6'o21, 8'h00, 0, 6'o21, 1,  1, 1, 1, 8'h11, 3, 1, 3);
    add(0, 0, 6'o21, 8'h00, 0, 6'o21, 1,  1, 1, 1, 8'h12, 2, 1, 3);
    add(0, 0, 6'o21, 8'h00, 0, 6'o21, 1,  1, 1, 1, 8'h13, 1, 1, 3);
    add(0, 0, 6'o21, 8'h00, 0, 6'o21, 1,  1, 1, 0, 8'h20, 0, 1, 3);
    add(1, 0, 6'o21, 8'h40, 0, 6'o21, 1,  1, 0, 0, 8'h00, 0, 0, 3);
    add(0, 0, 6'o21, 8'h00, 0, 6'o21, 1,  1, 1, 0, 8'h40, 0, 1, 3);
    add(0, 0, 6'o21, 8'h00, 0, 6'o21, 1,  1, 0, 0, 8'h00, 0, 0, 3);

    // Reset state
    up_type = 2'd1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_vld", pkt_in_vld, 1'b0);
    chk("rst_up_rdy", up_rdy, 1'b1);
    chk("rst_hi_occ", hi_occ, '0);
    chk("rst_lo_occ", lo_occ, '0);
    chk("rst_drop_cnt", drop_cnt, '0);
    rst_n = 1'b1;
    model_reset();
    @(posedge clk); #1;

    // Directed vector table
    foreach (tbl[i]) begin
      drive(tbl[i].uv, tbl[i].uq, tbl[i].ut, tbl[i].ud, tbl[i].pr);
      pg_en = tbl[i].pe; pg_node = tbl[i].pn;
      step();
      chk($sformatf("tbl%0d_up_rdy", i), s_rdy, tbl[i].er);
      chk($sformatf("tbl%0d_vld", i), s_vld, tbl[i].ev);
      if (tbl[i].ev) begin
        chk($sformatf("tbl%0d_qos", i), s_qos, tbl[i].eq);
        chk($sformatf("tbl%0d_data", i), s_data, tbl[i].ed);
      end
      chk($sformatf("tbl%0d_hi_occ", i), s_ho, tbl[i].eho);
      chk($sformatf("tbl%0d_lo_occ", i), s_lo, tbl[i].elo);
      chk($sformatf("tbl%0d_drop", i), s_drop, tbl[i].edr);
    end
    pg_en = 1'b0;
    drain();

    // Starvation: high stays busy, one low waits, expect 8 high grants then low
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 1'b1, 6'o07, 8'h80 + 8'(i), 1'b0);
      step();
    end
    drive(1'b1, 1'b0, 6'o07, 8'hC0, 1'b0);
    step();
    hi_grants = 0;
    lo_seen = 0;
    for (int c = 0; c < 40 && lo_seen == 0; c++) begin
      drive(1'b1, 1'b1, 6'o07, 8'h90 + 8'(c), 1'b1);
      step();
      if (s_hs) begin
        if (s_qos) hi_grants++;
        else begin
          lo_seen = 1;
          chk("starve_lo_data", s_data, 8'hC0);
        end
      end
    end
    chk("starve_lo_granted", lo_seen, 1);
    chk("starve_hi_grants", hi_grants, STARVE_MAX);
    drain();

    // Pending low offer stays put when high arrives behind it
    drive(1'b1, 1'b0, 6'o01, 8'h55, 1'b0);
    step();
    drive(1'b1, 1'b1, 6'o02, 8'h66, 1'b0);
    step();
    drive(1'b0, 1'b0, 6'o00, 8'h00, 1'b0);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("stable_qos", s_qos, 1'b0);
      chk("stable_data", s_data, 8'h55);
    end
    pkt_in_rdy = 1'b1;
    step();
    chk("stable_hs_lo", {s_hs, s_qos, s_data}, {1'b1, 1'b0, 8'h55});
    step();
    chk("stable_hs_hi", {s_hs, s_qos, s_data}, {1'b1, 1'b1, 8'h66});
    drain();

    // Randomized traffic against the model
    for (int c = 0; c < 600; c++) begin
      up_vld     = 1'($urandom_range(0, 1));
      up_qos     = 1'($urandom_range(0, 1));
      up_type    = 2'($urandom);
      up_tgt     = tg[$urandom_range(0, 3)];
      up_data    = 8'($urandom);
      pkt_in_rdy = ($urandom_range(0, 9) < 6);
      pg_node    = 6'o21;
      if ($urandom_range(0, 15) == 0) pg_en = ~pg_en;
      step();
    end
    pg_en = 1'b0;

    // Reset with packets queued and an offer on the port
    drain();
    drive(1'b1, 1'b1, 6'o05, 8'hE1, 1'b0); step();
    drive(1'b1, 1'b0, 6'o05, 8'hE2, 1'b0); step();
    drive(1'b1, 1'b1, 6'o05, 8'hE3, 1'b0); step();
    drive(1'b0, 1'b0, 6'o05, 8'h00, 1'b0); step();
    chk("pre_rst_vld", s_vld, 1'b1);
    chk("pre_rst_occ", s_ho + s_lo, 3);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_vld", pkt_in_vld, 1'b0);
    chk("mid_rst_hi_occ", hi_occ, '0);
    chk("mid_rst_lo_occ", lo_occ, '0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    step();
    chk("post_rst_drop_cnt", s_drop, 0);
    chk("post_rst_vld", s_vld, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
